lcd_frame_composer: RTL and testbench
=====================================

Name: lcd_frame_composer

Overview:
Double-buffered frame store that sits directly upstream of the LCD graphic driver. The game renderer builds the next frame in the back bank using a command stream (byte write, OR-merge, fill, commit). Meanwhile the driver reads the front bank through a registered 1-cycle read port. A commit waits until the driver is in HALT, swaps the banks, and then issues the start pulse that the driver's falling-edge detector needs.

Parameters:
- START_LEN, 2, number of cycles start_o is held high (must be at least 2 for the driver's 2-stage edge detector).
- BUSY_TIMEOUT, 64, number of cycles to wait for the driver to leave HALT after start before giving up.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_op_i  in  2  00 WRITE, 01 OR, 10 FILL, 11 COMMIT
- cmd_addr_i  in  11  {x[4:0],y[5:0]}; x[4:3]=chip, x[2:0]=page, y=column
- cmd_data_i  in  8  write/OR byte, or FILL pattern
- rd_addr_i  in  11  driver address (addr_o of the driver)
- rd_data_o  out  8  front-bank byte; registered, 1-cycle latency
- drv_state_i  in  3  driver state; 3'd7 = HALT
- start_o  out  1  start pulse to the driver
- front_o  out  1  current front bank index
- busy_o  out  1  high whenever the FSM is not IDLE
- timeout_o  out  1  sticky flag, set when BUSY_TIMEOUT expires; cleared by reset

Behaviour:
- Storage: 2 banks x 2048 x 8. One write port (back bank). Two read ports: driver read from the front bank, RMW read from the back bank. Memory contents are not reset.
- Reset values: cmd_ready_o=1, rd_data_o=0, start_o=0, front_o=0, busy_o=0, timeout_o=0, state=IDLE.
- Reads: rd_data_o <= mem[front][rd_addr_i] every cycle. The read is independent of the FSM. Writes never target the front bank.
- cmd_ready_o = (state==IDLE). A command is accepted on the cycle where valid & ready.
- FSM states: IDLE, RMW_RD, RMW_WR, FILL, WAIT_HALT, START, WAIT_BUSY.
- WRITE: written in the acceptance cycle; stays in IDLE. Back-to-back WRITEs run at 1 per cycle.
  - IDLE -> RMW_RD: latch addr/data, read the back bank.
  - RMW_WR: write old|data.
  - -> IDLE. Total 3 cycles per OR (accept, read, write).
- FILL: IDLE -> FILL.
  - Latch the pattern and set counter=0.
  - Write mem[back][counter] each cycle.
  - counter 11 bits; after writing address 2047 (counter wraps to 0) -> IDLE.
  - Total 2048 write cycles.
- COMMIT:
  - IDLE -> WAIT_HALT.
  - Stay until drv_state_i==3'd7. Then toggle front_o (the swap is visible on the read port from the next cycle) and go to START.
  - START: hold start_o=1 for START_LEN cycles, then drive start_o=0 and go to WAIT_BUSY.
  - WAIT_BUSY: go to IDLE when drv_state_i!=3'd7, or when the timeout counter reaches BUSY_TIMEOUT (then set timeout_o=1 and go to IDLE).
- The back bank is not cleared by COMMIT; the renderer issues FILL itself.
- Commands presented while busy are held by the source (cmd_ready_o=0). No command is dropped or queued.
- Reset mid-operation: return to IDLE immediately. start_o drops asynchronously and front_o returns to 0. A partially filled bank is left as is.
- A drv_state_i value other than 7 during WAIT_HALT simply stalls; there is no timeout there.

Optional Feature:
- Macro FRAME_COMPOSER_INVERT_EN.
- Defined:
  - Adds input port invert_i (1 bit).
  - invert_i is sampled on the swap cycle of COMMIT into an inv register (reset 0).
  - rd_data_o = inv ? ~mem : mem. This gives night mode per frame with no tearing mid-frame.
- Undefined: no port, no register; rd_data_o is the raw byte.

Test Plan:
- Reset, then WRITE addr 11'h000 data 8'hA5 and COMMIT with drv_state_i=7. Expected: front_o 0->1; start_o high for exactly 2 cycles; rd_addr_i=0 gives rd_data_o=8'hA5 one cycle later.
- WRITE 11'h07F=8'h0F, OR 11'h07F=8'hF0, COMMIT. Expected: read of 11'h07F gives 8'hFF; the OR holds cmd_ready_o low for 2 cycles.
- FILL 8'h00 on the back bank, then COMMIT. Expected: busy_o high for 2048 cycles; reads of addresses 0, 1023 and 2047 all give 8'h00; the other bank's contents are unchanged.
- COMMIT while drv_state_i=0, then drv_state_i=7 after 100 cycles. Expected: front_o unchanged and start_o=0 for those 100 cycles; the swap and start follow.
- COMMIT with drv_state_i stuck at 7. Expected: after the start pulse plus 64 cycles, timeout_o=1 and the FSM returns to IDLE.
- Assert rstn=0 mid-FILL and mid-START. Expected: start_o=0 and front_o=0 immediately; cmd_ready_o=1 after release.

Source files
------------

// File: rtl/lcd_frame_composer.sv
// Double-buffered LCD frame store: command-driven back-bank rendering, registered front-bank read port.
// Optional per-frame inversion enabled by defining FRAME_COMPOSER_INVERT_EN.
`timescale 1ns/1ps
module lcd_frame_composer #(
   parameter int unsigned START_LEN    = 2,
   parameter int unsigned BUSY_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic [10:0] cmd_addr_i,
   input  logic [7:0]  cmd_data_i,
   input  logic [10:0] rd_addr_i,
   output logic [7:0]  rd_data_o,
   input  logic [2:0]  drv_state_i,
`ifdef FRAME_COMPOSER_INVERT_EN
   input  logic        invert_i,
`endif
   output logic        start_o,
   output logic        front_o,
   output logic        busy_o,
   output logic        timeout_o
);

   localparam int unsigned AW = 11;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 11;
   localparam int unsigned DEPTH = 2 * (2 ** AW);
   localparam logic [2:0] DRV_HALT = 3'd7;
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_OR    = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b10;

   typedef enum logic [2:0] {
      IDLE, RMW_RD, RMW_WR, FILL, WAIT_HALT, START, WAIT_BUSY
   } state_t;

   state_t state, state_n;
   logic [AW-1:0] addr_q, addr_n;
   logic [DW-1:0] data_q, data_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic front_q, front_n;
   logic timeout_q, timeout_n;
   logic cmd_ready_q, busy_q, start_q;
   logic [DW-1:0] rd_q, rmw_q;
   logic mem_we_c;
   logic [AW-1:0] mem_waddr_c;
   logic [DW-1:0] mem_wdata_c;
   logic accept_c;
`ifdef FRAME_COMPOSER_INVERT_EN
   logic inv_q, inv_n;
`endif

   logic [DW-1:0] mem [DEPTH];

   assign accept_c = cmd_valid_i & cmd_ready_q;

   // Next-state, datapath latches and back-bank write port control.
   always_comb begin
      state_n     = state;
      addr_n      = addr_q;
      data_n      = data_q;
      cnt_n       = cnt_q;
      front_n     = front_q;
      timeout_n   = timeout_q;
      mem_we_c    = 1'b0;
      mem_waddr_c = addr_q;
      mem_wdata_c = data_q;
`ifdef FRAME_COMPOSER_INVERT_EN
      inv_n       = inv_q;
`endif
      case (state)
         IDLE: begin
            if (accept_c) begin
               case (cmd_op_i)
                  OP_WRITE: begin
                     mem_we_c    = 1'b1;
                     mem_waddr_c = cmd_addr_i;
                     mem_wdata_c = cmd_data_i;
                  end
                  OP_OR: begin
                     addr_n  = cmd_addr_i;
                     data_n  = cmd_data_i;
                     state_n = RMW_RD;
                  end
                  OP_FILL: begin
                     data_n  = cmd_data_i;
                     cnt_n   = '0;
                     state_n = FILL;
                  end
                  default: state_n = WAIT_HALT;
               endcase
            end
         end
         RMW_RD: state_n = RMW_WR;
         RMW_WR: begin
            mem_we_c    = 1'b1;
            mem_wdata_c = rmw_q | data_q;
            state_n     = IDLE;
         end
         FILL: begin
            mem_we_c    = 1'b1;
            mem_waddr_c = cnt_q;
            cnt_n       = cnt_q + CW'(1);
            if (cnt_q == '1) state_n = IDLE;
         end
         WAIT_HALT: begin
            if (drv_state_i == DRV_HALT) begin
               front_n = ~front_q;
`ifdef FRAME_COMPOSER_INVERT_EN
               inv_n   = invert_i;
`endif
               cnt_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (cnt_q == CW'(START_LEN - 1)) begin
               cnt_n   = '0;
               state_n = WAIT_BUSY;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         WAIT_BUSY: begin
            if (drv_state_i != DRV_HALT) begin
               state_n = IDLE;
            end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
               timeout_n = 1'b1;
               state_n   = IDLE;
            end else begin
               cnt_n = cnt_q + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Control registers; status outputs are registered from the next state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         front_q     <= 1'b0;
         timeout_q   <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         rd_q        <= '0;
`ifdef FRAME_COMPOSER_INVERT_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         addr_q      <= addr_n;
         data_q      <= data_n;
         cnt_q       <= cnt_n;
         front_q     <= front_n;
         timeout_q   <= timeout_n;
         cmd_ready_q <= (state_n == IDLE);
         busy_q      <= (state_n != IDLE);
         start_q     <= (state_n == START);
`ifdef FRAME_COMPOSER_INVERT_EN
         inv_q       <= inv_n;
         rd_q        <= inv_q ? ~mem[{front_q, rd_addr_i}] : mem[{front_q, rd_addr_i}];
`else
         rd_q        <= mem[{front_q, rd_addr_i}];
`endif
      end
   end

   // Back-bank write port and RMW read port; contents are never reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) mem[{~front_q, mem_waddr_c}] <= mem_wdata_c;
      rmw_q <= mem[{~front_q, addr_q}];
   end

   assign cmd_ready_o = cmd_ready_q;
   assign rd_data_o   = rd_q;
   assign start_o     = start_q;
   assign front_o     = front_q;
   assign busy_o      = busy_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_lcd_frame_composer.sv
// Self-checking bench for lcd_frame_composer: directed test-plan cases plus a
// randomized command phase checked against a two-bank array model.
`timescale 1ns/1ps
module tb_lcd_frame_composer;

   localparam int unsigned START_LEN    = 2;
   localparam int unsigned BUSY_TIMEOUT = 64;
   localparam logic [1:0] OP_WRITE  = 2'b00;
   localparam logic [1:0] OP_OR     = 2'b01;
   localparam logic [1:0] OP_FILL   = 2'b10;
   localparam logic [1:0] OP_COMMIT = 2'b11;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i = '0;
   logic [10:0] cmd_addr_i = '0;
   logic [7:0]  cmd_data_i = '0;
   logic [10:0] rd_addr_i = '0;
   logic [7:0]  rd_data_o;
   logic [2:0]  drv_state_i = 3'd7;
   logic        start_o, front_o, busy_o, timeout_o;
`ifdef FRAME_COMPOSER_INVERT_EN
   logic        invert_i = 1'b0;
`endif

   lcd_frame_composer #(.START_LEN(START_LEN), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
      .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .drv_state_i(drv_state_i),
`ifdef FRAME_COMPOSER_INVERT_EN
      .invert_i(invert_i),
`endif
      .start_o(start_o), .front_o(front_o), .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: contents of each bank, whether each byte is defined, which bank is shown.
   logic [7:0] model [2][2048];
   bit         known [2][2048];
   bit         m_front = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one command at a negedge and hold it until accepted.
   task automatic send_cmd(input logic [1:0] op, input logic [10:0] addr, input logic [7:0] data);
      int n;
      bit b;
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_addr_i  = addr;
      cmd_data_i  = data;
      n = 0;
      while (!cmd_ready_o && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready_o) check_eq("cmd_ready_wait", 32'(cmd_ready_o), 32'd1);
      @(negedge clk);
      cmd_valid_i = 1'b0;
      b = !m_front;
      case (op)
         OP_WRITE: begin
            model[b][addr] = data;
            known[b][addr] = 1'b1;
         end
         OP_OR: model[b][addr] = model[b][addr] | data;
         OP_FILL: for (int i = 0; i < 2048; i++) begin
            model[b][i] = data;
            known[b][i] = 1'b1;
         end
         default: ;
      endcase
   endtask

   task automatic check_rd(input logic [10:0] addr, input string tag);
      rd_addr_i = addr;
      @(negedge clk);
      if (known[m_front][addr]) check_eq(tag, 32'(rd_data_o), 32'(model[m_front][addr]));
   endtask

   // After a COMMIT is accepted: observe swap and start pulse, then release or time out.
   task automatic finish_commit(input bit stuck);
      int n;
      n = 0;
      while (!start_o && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_eq("start_rise", 32'(start_o), 32'd1);
      m_front = !m_front;
      n = 0;
      while (start_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("start_len", 32'(n), 32'(START_LEN));
      check_eq("front_swap", 32'(front_o), 32'(m_front));
      if (!stuck) begin
         drv_state_i = 3'd0;
         n = 0;
         while (busy_o && n < 100) begin
            @(negedge clk);
            n++;
         end
         check_eq("busy_release", 32'(busy_o), 32'd0);
         drv_state_i = 3'd7;
      end else begin
         n = 0;
         while (!timeout_o && n < 1000) begin
            @(negedge clk);
            n++;
         end
         check_eq("timeout_cycles", 32'(n), 32'(BUSY_TIMEOUT));
         check_eq("timeout_flag", 32'(timeout_o), 32'd1);
         check_eq("timeout_idle", 32'(busy_o), 32'd0);
      end
   endtask

   initial begin
      int n;
      int bad;
      int sel;
      logic [10:0] a;
      logic [7:0] d;

      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(cmd_ready_o), 32'd1);
      check_eq("rst_rd_data", 32'(rd_data_o), 32'd0);
      check_eq("rst_start", 32'(start_o), 32'd0);
      check_eq("rst_front", 32'(front_o), 32'd0);
      check_eq("rst_busy", 32'(busy_o), 32'd0);
      check_eq("rst_timeout", 32'(timeout_o), 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      // Single write then commit.
      send_cmd(OP_WRITE, 11'h000, 8'hA5);
      send_cmd(OP_COMMIT, 11'h000, 8'h00);
      finish_commit(1'b0);
      check_rd(11'h000, "rd_a5");

      // Write + OR merge.
      send_cmd(OP_WRITE, 11'h07F, 8'h0F);
      send_cmd(OP_OR, 11'h07F, 8'hF0);
      n = 0;
      while (!cmd_ready_o && n < 100) begin
         n++;
         @(negedge clk);
      end
      check_eq("or_ready_low", 32'(n), 32'd2);
      send_cmd(OP_COMMIT, 11'h000, 8'h00);
      finish_commit(1'b0);
      check_rd(11'h07F, "rd_or_merge");
      check_eq("or_value", 32'(model[m_front][11'h07F]), 32'h0000_00FF);

      // Fill back bank with zero.
      send_cmd(OP_FILL, 11'h000, 8'h00);
      n = 0;
      while (busy_o && n < 5000) begin
         n++;
         @(negedge clk);
      end
      check_eq("fill_busy_len", 32'(n), 32'd2048);
      send_cmd(OP_COMMIT, 11'h000, 8'h00);
      finish_commit(1'b0);
      check_rd(11'h000, "fill_rd_0");
      check_rd(11'd1023, "fill_rd_1023");
      check_rd(11'd2047, "fill_rd_2047");
      send_cmd(OP_COMMIT, 11'h000, 8'h00);
      finish_commit(1'b0);
      check_rd(11'h07F, "other_bank_kept");

      // Commit stalls while driver is not halted.
      drv_state_i = 3'd0;
      send_cmd(OP_COMMIT, 11'h000, 8'h00);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (front_o !== m_front || start_o !== 1'b0) bad++;
      end
      check_eq("stall_hold", 32'(bad), 32'd0);
      drv_state_i = 3'd7;
      finish_commit(1'b0);

      // Driver never leaves HALT.
      send_cmd(OP_COMMIT, 11'h000, 8'h00);
      finish_commit(1'b1);

      // Randomized phase: both banks fully defined first.
      send_cmd(OP_FILL, 11'h000, 8'($urandom));
      send_cmd(OP_COMMIT, 11'h000, 8'h00);
      finish_commit(1'b0);
      send_cmd(OP_FILL, 11'h000, 8'($urandom));
      for (int it = 0; it < 60; it++) begin
         sel = int'($urandom_range(0, 99));
         a   = 11'($urandom_range(0, 47));
         d   = 8'($urandom);
         if (sel < 40)      send_cmd(OP_WRITE, a, d);
         else if (sel < 70) send_cmd(OP_OR, a, d);
         else if (sel < 82) begin
            send_cmd(OP_COMMIT, 11'h000, 8'h00);
            finish_commit(1'b0);
         end else           check_rd(a, "rand_rd");
      end
      send_cmd(OP_COMMIT, 11'h000, 8'h00);
      finish_commit(1'b0);
      for (int i = 0; i < 48; i += 3) check_rd(11'(i), "rand_sweep");
      check_eq("timeout_sticky", 32'(timeout_o), 32'd1);

      // Reset in the middle of a FILL.
      send_cmd(OP_FILL, 11'h000, 8'h5A);
      repeat (100) @(negedge clk);
      rstn = 1'b0;
      #1;
      check_eq("rst_fill_start", 32'(start_o), 32'd0);
      check_eq("rst_fill_front", 32'(front_o), 32'd0);
      check_eq("rst_fill_busy", 32'(busy_o), 32'd0);
      check_eq("rst_fill_timeout", 32'(timeout_o), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_eq("rst_fill_ready", 32'(cmd_ready_o), 32'd1);

      // Reset while the start pulse is high.
      send_cmd(OP_COMMIT, 11'h000, 8'h00);
      n = 0;
      while (!start_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("mid_start_high", 32'(start_o), 32'd1);
      check_eq("mid_start_front", 32'(front_o), 32'd1);
      rstn = 1'b0;
      #1;
      check_eq("rst_start_start", 32'(start_o), 32'd0);
      check_eq("rst_start_front", 32'(front_o), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_eq("rst_start_ready", 32'(cmd_ready_o), 32'd1);
      check_eq("rst_start_busy", 32'(busy_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
